// File: rtl/dmem_responder.sv
// Handshaked data-memory responder: one RV32I load/store at a time, a fixed
// programmable wait, then a response held until the requester consumes it.
module dmem_responder #(
   parameter int unsigned W           = 32,
   parameter int unsigned ADDR_W      = 10,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic         req_write,
   input  logic [W-1:0] req_addr,
   input  logic [2:0]   req_funct3,
   input  logic [W-1:0] req_wdata,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [W-1:0] rsp_rdata,
   output logic         rsp_err
);

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_t;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              wr_q;
   logic [W-1:0]      addr_q, wdata_q;
   logic [2:0]        f3_q;
   logic [W-1:0]      rdata_q;
   logic              err_q;
   logic [W-1:0]      mem [2**ADDR_W];

   logic              in_idle, accept, enter_resp, we;
   logic              cur_wr, cur_err;
   logic [W-1:0]      cur_addr, cur_wdata;
   logic [2:0]        cur_f3;
   logic [ADDR_W-1:0] idx;
   logic [1:0]        lane;
   logic [W-1:0]      rd_word, ld_data, st_word;
   logic [7:0]        byte_v;
   logic [15:0]       half_v;
   logic [3:0]        be;

   assign in_idle = (state_q == StIdle);
   assign accept  = in_idle & req_valid;

   // With no wait states the access happens on the accept edge, so the live request drives it.
   assign cur_wr    = in_idle ? req_write  : wr_q;
   assign cur_addr  = in_idle ? req_addr   : addr_q;
   assign cur_f3    = in_idle ? req_funct3 : f3_q;
   assign cur_wdata = in_idle ? req_wdata  : wdata_q;

   assign idx     = cur_addr[ADDR_W+1:2];
   assign lane    = cur_addr[1:0];
   assign rd_word = mem[idx];

   always_comb begin
      cur_err = 1'b0;
      case (cur_f3)
         3'b000, 3'b100: cur_err = 1'b0;
         3'b001, 3'b101: cur_err = cur_addr[0];
         3'b010:         cur_err = |cur_addr[1:0];
         default:        cur_err = 1'b1;
      endcase
      if (cur_wr && cur_f3[2]) cur_err = 1'b1;
      if (|cur_addr[W-1:ADDR_W+2]) cur_err = 1'b1;
   end

   always_comb begin
      ld_data = '0;
      byte_v  = rd_word[{lane, 3'b000} +: 8];
      half_v  = rd_word[{lane[1], 4'b0000} +: 16];
      case (cur_f3[1:0])
         2'b00:   ld_data = cur_f3[2] ? {{(W-8){1'b0}}, byte_v} : {{(W-8){byte_v[7]}}, byte_v};
         2'b01:   ld_data = cur_f3[2] ? {{(W-16){1'b0}}, half_v} :
                                        {{(W-16){half_v[15]}}, half_v};
         2'b10:   ld_data = rd_word;
         default: ld_data = '0;
      endcase
   end

   always_comb begin
      be      = 4'b0000;
      st_word = cur_wdata;
      case (cur_f3[1:0])
         2'b00: begin
            be      = 4'b0001 << lane;
            st_word = {4{cur_wdata[7:0]}};
         end
         2'b01: begin
            be      = lane[1] ? 4'b1100 : 4'b0011;
            st_word = {2{cur_wdata[15:0]}};
         end
         2'b10:   be = 4'b1111;
         default: be = 4'b0000;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         StIdle: begin
            if (req_valid) begin
               if (WAIT_CYCLES == 0) begin
                  state_d = StResp;
               end else begin
                  state_d = StWait;
                  cnt_d   = 4'(WAIT_CYCLES - 1);
               end
            end
         end
         StWait: begin
            if (cnt_q == 4'd0) state_d = StResp;
            else               cnt_d   = cnt_q - 4'd1;
         end
         StResp: begin
            if (rsp_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign enter_resp = (state_d == StResp) && (state_q != StResp);
   // A store held in reset must never commit, even with zero wait states.
   assign we         = enter_resp & cur_wr & ~cur_err & ~reset;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (enter_resp) begin
            err_q   <= cur_err;
            rdata_q <= (cur_err | cur_wr) ? '0 : ld_data;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_q    <= 1'b0;
         addr_q  <= '0;
         f3_q    <= 3'b000;
         wdata_q <= '0;
      end else if (accept) begin
         wr_q    <= req_write;
         addr_q  <= req_addr;
         f3_q    <= req_funct3;
         wdata_q <= req_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[idx][8*i +: 8] <= st_word[8*i +: 8];
         end
      end
   end

   assign req_ready = in_idle;
   assign rsp_valid = (state_q == StResp);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

endmodule
